// File: rtl/tdc_code_accumulator_pkg.sv
// Shared types and constants for the TDC code accumulator slice.
package tdc_pkg;

  localparam int TAP_W  = 4;
  localparam int CODE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam logic [1:0] SEL_MEAN   = 2'd0;
  localparam logic [1:0] SEL_MINMAX = 2'd1;
  localparam logic [1:0] SEL_BUBBLE = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

endpackage

// File: rtl/tdc_code_accumulator_if.sv
// Sample/control/readout bundle between the TDC stage, the container mux and the accumulator.
interface tdc_code_accumulator_if;
  import tdc_pkg::*;

  logic [CODE_W-1:0] sample_i;
  logic              sample_valid_i;
  logic              start_i;
  logic [1:0]        sel_i;
  logic [7:0]        data_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output sample_i, sample_valid_i, start_i, sel_i,
    input  data_o, busy_o, done_o
  );

  modport slave (
    input  sample_i, sample_valid_i, start_i, sel_i,
    output data_o, busy_o, done_o
  );

endinterface

// File: rtl/tdc_therm_decode.sv
// Combinational thermometer decode: tap count plus a flag for codes that are not a clean run of ones from bit0.
module tdc_therm_decode
  import tdc_pkg::*;
(
  input  logic [CODE_W-1:0] sample_i,
  output logic [TAP_W-1:0]  taps_o,
  output logic              bubble_o
);

  always_comb begin
    taps_o = '0;
    for (int i = 0; i < CODE_W; i++) begin
      taps_o = taps_o + TAP_W'(sample_i[i]);
    end
  end

  // A clean code 2^k-1 has no bit in common with itself plus one.
  assign bubble_o = |(sample_i & (sample_i + CODE_W'(1)));

endmodule

// File: rtl/tdc_code_accumulator.sv
// Accumulates 2^LOG2_N decoded TDC samples into mean/min/max/bubble statistics with a byte-wide readout.
module tdc_code_accumulator
  import tdc_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input logic                  clk,
  input logic                  rst,
  tdc_code_accumulator_if.slave bus
);

  localparam int SUM_W = LOG2_N + 4;
  localparam int CNT_W = LOG2_N + 1;
  localparam int NSAMP = 1 << LOG2_N;

  generate
    if ((LOG2_N < 4) || (LOG2_N > 8)) begin : g_badLog2N
      $error("tdc_code_accumulator: LOG2_N must be within 4..8");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TAP_W-1:0]   minTap_q, minTap_d;
  logic [TAP_W-1:0]   maxTap_q, maxTap_d;
  logic [7:0]         bubbleCnt_q, bubbleCnt_d;
  logic               doneFlag_q, doneFlag_d;
  logic               donePulse_q, donePulse_d;
  logic [7:0]         data_q, data_d;

  logic [TAP_W-1:0]   taps;
  logic               bubble;
  logic               accept;
  logic               busy;

  tdc_therm_decode u_decode (
    .sample_i (bus.sample_i),
    .taps_o   (taps),
    .bubble_o (bubble)
  );

  assign busy   = (state_q == ACCUM);
  assign accept = busy && bus.sample_valid_i && !bus.start_i;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    count_d     = count_q;
    minTap_d    = minTap_q;
    maxTap_d    = maxTap_q;
    bubbleCnt_d = bubbleCnt_q;
    doneFlag_d  = doneFlag_q;
    donePulse_d = 1'b0;
    data_d      = '0;

    // Start from any state (including mid-run) wins over a coincident sample.
    if (bus.start_i) begin
      state_d     = ACCUM;
      sum_d       = '0;
      count_d     = '0;
      minTap_d    = 4'hF;
      maxTap_d    = '0;
      bubbleCnt_d = '0;
      doneFlag_d  = 1'b0;
    end else if (accept) begin
      sum_d   = sum_q + {{LOG2_N{1'b0}}, taps};
      count_d = count_q + CNT_W'(1);
      if (taps < minTap_q) minTap_d = taps;
      if (taps > maxTap_q) maxTap_d = taps;
      if (bubble && (bubbleCnt_q != 8'hFF)) bubbleCnt_d = bubbleCnt_q + 8'd1;
      if (count_q == CNT_W'(NSAMP - 1)) begin
        state_d     = DONE;
        doneFlag_d  = 1'b1;
        donePulse_d = 1'b1;
      end
    end

    // Readout is taken from the current registers, so it lags sel_i by one cycle.
    case (bus.sel_i)
      SEL_MEAN:   data_d = 8'(sum_q >> (LOG2_N - 4));
      SEL_MINMAX: data_d = {minTap_q, maxTap_q};
      SEL_BUBBLE: data_d = bubbleCnt_q;
      SEL_STATUS: data_d = {busy, doneFlag_q, 2'b00, count_q[3:0]};
      default:    data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      count_q     <= '0;
      minTap_q    <= '0;
      maxTap_q    <= '0;
      bubbleCnt_q <= '0;
      doneFlag_q  <= 1'b0;
      donePulse_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      minTap_q    <= minTap_d;
      maxTap_q    <= maxTap_d;
      bubbleCnt_q <= bubbleCnt_d;
      doneFlag_q  <= doneFlag_d;
      donePulse_q <= donePulse_d;
      data_q      <= data_d;
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = donePulse_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_tdc_code_accumulator.sv
// Scoreboard bench for tdc_code_accumulator: a LOG2_N=4 instance for most runs, a LOG2_N=8 instance for saturation.
module tb_tdc_code_accumulator;
  import tdc_pkg::*;

  typedef logic [7:0] code_q_t[$];

  typedef struct packed {
    logic [7:0] mean;
    logic [7:0] minMax;
    logic [7:0] bubbles;
    logic [7:0] status;
  } result_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tdc_code_accumulator_if if4 ();
  tdc_code_accumulator_if if8 ();

  tdc_code_accumulator #(.LOG2_N(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  tdc_code_accumulator #(.LOG2_N(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  int      total    = 0;
  int      bad      = 0;
  int      doneCnt4 = 0;
  int      doneCnt8 = 0;
  result_t expQ[$];

  always @(posedge clk) begin
    if (if4.done_o === 1'b1) doneCnt4++;
    if (if8.done_o === 1'b1) doneCnt8++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic getBusy(input bit use8);
    return use8 ? if8.busy_o : if4.busy_o;
  endfunction

  function automatic logic getDone(input bit use8);
    return use8 ? if8.done_o : if4.done_o;
  endfunction

  function automatic logic [7:0] getData(input bit use8);
    return use8 ? if8.data_o : if4.data_o;
  endfunction

  task automatic applyStimulus(input bit use8, input logic st, input logic v,
                               input logic [7:0] s, input logic [1:0] sel);
    if (use8) begin
      if8.start_i = st; if8.sample_valid_i = v; if8.sample_i = s; if8.sel_i = sel;
    end else begin
      if4.start_i = st; if4.sample_valid_i = v; if4.sample_i = s; if4.sel_i = sel;
    end
    @(posedge clk);
    #1;
    if (use8) begin
      if8.start_i = 1'b0; if8.sample_valid_i = 1'b0;
    end else begin
      if4.start_i = 1'b0; if4.sample_valid_i = 1'b0;
    end
  endtask

  task automatic readAll(input bit use8, output result_t r);
    applyStimulus(use8, 1'b0, 1'b0, 8'h00, SEL_MEAN);
    r.mean = getData(use8);
    applyStimulus(use8, 1'b0, 1'b0, 8'h00, SEL_MINMAX);
    r.minMax = getData(use8);
    applyStimulus(use8, 1'b0, 1'b0, 8'h00, SEL_BUBBLE);
    r.bubbles = getData(use8);
    applyStimulus(use8, 1'b0, 1'b0, 8'h00, SEL_STATUS);
    r.status = getData(use8);
  endtask

  task automatic compareResult(input string tag, input result_t got, input result_t exp);
    checkOutput({tag, "_mean"},    16'(got.mean),    16'(exp.mean));
    checkOutput({tag, "_minmax"},  16'(got.minMax),  16'(exp.minMax));
    checkOutput({tag, "_bubbles"}, 16'(got.bubbles), 16'(exp.bubbles));
    checkOutput({tag, "_status"},  16'(got.status),  16'(exp.status));
  endtask

  // Reference statistics straight from the stimulus, with bubbles judged against the list of clean codes.
  function automatic result_t modelRun(input code_q_t codes, input int log2n);
    result_t r;
    int sum = 0, mn = 15, mx = 0, b = 0;
    foreach (codes[i]) begin
      int t;
      bit clean;
      t = $countones(codes[i]);
      sum += t;
      if (t < mn) mn = t;
      if (t > mx) mx = t;
      clean = 1'b0;
      for (int k = 0; k <= 8; k++) if (codes[i] == 8'((1 << k) - 1)) clean = 1'b1;
      if (!clean && b < 255) b++;
    end
    r.mean    = 8'(sum >> (log2n - 4));
    r.minMax  = {4'(mn), 4'(mx)};
    r.bubbles = 8'(b);
    r.status  = {1'b0, 1'b1, 2'b00, 4'(codes.size())};
    return r;
  endfunction

  task automatic runCapture(input string tag, input bit use8, input int log2n,
                            input code_q_t codes, input bit gaps, output result_t exp);
    result_t got;
    int d0;
    bit busyLow = 1'b0;
    bit earlyDone = 1'b0;
    expQ.push_back(modelRun(codes, log2n));
    d0 = use8 ? doneCnt8 : doneCnt4;
    applyStimulus(use8, 1'b1, 1'b0, 8'h00, SEL_STATUS);
    for (int i = 0; i < codes.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          applyStimulus(use8, 1'b0, 1'b0, 8'h00, SEL_STATUS);
          if (getBusy(use8) !== 1'b1) busyLow = 1'b1;
          if (getDone(use8) !== 1'b0) earlyDone = 1'b1;
        end
      end
      applyStimulus(use8, 1'b0, 1'b1, codes[i], SEL_STATUS);
      if (i != codes.size() - 1) begin
        if (getBusy(use8) !== 1'b1) busyLow = 1'b1;
        if (getDone(use8) !== 1'b0) earlyDone = 1'b1;
      end
    end
    checkOutput({tag, "_busy_in_run"}, 16'(busyLow), 16'd0);
    checkOutput({tag, "_no_early_done"}, 16'(earlyDone), 16'd0);
    checkOutput({tag, "_done_after_last"}, 16'(getDone(use8)), 16'd1);
    checkOutput({tag, "_busy_after_last"}, 16'(getBusy(use8)), 16'd0);
    applyStimulus(use8, 1'b0, 1'b0, 8'h00, SEL_MEAN);
    checkOutput({tag, "_done_one_cycle"}, 16'(getDone(use8)), 16'd0);
    readAll(use8, got);
    exp = expQ.pop_front();
    compareResult(tag, got, exp);
    checkOutput({tag, "_done_count"}, 16'((use8 ? doneCnt8 : doneCnt4) - d0), 16'd1);
  endtask

  initial begin
    code_q_t cq;
    result_t got, exp;
    int d0;

    if4.sample_i = '0; if4.sample_valid_i = 1'b0; if4.start_i = 1'b0; if4.sel_i = SEL_MEAN;
    if8.sample_i = '0; if8.sample_valid_i = 1'b0; if8.start_i = 1'b0; if8.sel_i = SEL_MEAN;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data4", 16'(if4.data_o), 16'h00);
    checkOutput("rst_busy4", 16'(if4.busy_o), 16'd0);
    checkOutput("rst_done4", 16'(if4.done_o), 16'd0);
    checkOutput("rst_data8", 16'(if8.data_o), 16'h00);
    rst = 1'b0;
    readAll(1'b0, got);
    compareResult("rst_idle", got, 32'h0);

    cq.delete();
    repeat (16) cq.push_back(8'h0F);
    runCapture("run0F", 1'b0, 4, cq, 1'b0, exp);

    // Samples offered while DONE must leave every result untouched.
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, SEL_MEAN);
    readAll(1'b0, got);
    compareResult("done_ignore", got, exp);

    cq.delete();
    for (int i = 0; i < 16; i++) cq.push_back((i % 2 == 0) ? 8'h00 : 8'hFF);
    runCapture("alt", 1'b0, 4, cq, 1'b1, exp);

    cq.delete();
    repeat (16) cq.push_back(8'h05);
    runCapture("bub05", 1'b0, 4, cq, 1'b0, exp);

    d0 = doneCnt4;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, SEL_MEAN);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 8'h0F, SEL_MEAN);
    cq.delete();
    repeat (16) cq.push_back(8'h01);
    runCapture("restart", 1'b0, 4, cq, 1'b0, exp);
    checkOutput("restart_total_done", 16'(doneCnt4 - d0), 16'd1);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, SEL_STATUS);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, SEL_STATUS);
    checkOutput("start_drops_sample", 16'(if4.data_o), 16'h80);
    cq.delete();
    repeat (16) cq.push_back(8'h0F);
    runCapture("after_conflict", 1'b0, 4, cq, 1'b0, exp);

    d0 = doneCnt4;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, SEL_MEAN);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 8'h0F, SEL_MEAN);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy", 16'(if4.busy_o), 16'd0);
    readAll(1'b0, got);
    compareResult("midrst", got, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, SEL_MEAN);
    readAll(1'b0, got);
    compareResult("idle_ignore", got, 32'h0);
    checkOutput("midrst_no_done", 16'(doneCnt4 - d0), 16'd0);

    cq.delete();
    repeat (256) cq.push_back(8'hAA);
    runCapture("n256", 1'b1, 8, cq, 1'b0, exp);
    checkOutput("n256_bub_sat", 16'(exp.bubbles), 16'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_code_accumulator.md
Name: tdc_code_accumulator

Overview:
- Downstream consumer of the TDC stage; takes its 8-bit thermometer code per measurement.
- Converts each code to a 0..8 delay-tap count and flags thermometer bubbles.
- Accumulates 2^LOG2_N samples and reports mean (Q4.4), min, max and bubble count.
- Results are readable one byte at a time through a select, for the container's uo_out mux.

Parameters:
- LOG2_N, 4, log2 of samples per run; legal range 4..8, elaboration error otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sample_i  in  8  TDC thermometer code; bit0 is the first tap.
- sample_valid_i  in  1  qualifies sample_i for one cycle.
- start_i  in  1  begin (or restart) a run.
- sel_i  in  2  readout byte select.
- data_o  out  8  selected result byte.
- busy_o  out  1  high while in ACCUM.
- done_o  out  1  one-cycle pulse when a run completes.

Behaviour:
- Single clock: clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; sum, count, min, max, bubbles and done flag all 0; busy_o=0, done_o=0, data_o=0x00.
- Per-sample decode (combinational), done in a sub-module:
  - taps = popcount(sample_i), 0..8.
  - bubble = sample_i is not of the form 2^k-1 for k=0..8.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE --start_i--> ACCUM.
  - ACCUM --last sample accepted--> DONE.
  - DONE --start_i--> ACCUM.
- Entering ACCUM on the start_i edge:
  - sum=0, count=0, max=0, bubbles=0, done flag cleared.
  - min=4'hF as a sentinel.
  - The cycle carrying start_i does not accept a sample, even if sample_valid_i=1.
- ACCUM: each cycle with sample_valid_i=1:
  - sum += taps.
  - min = min(min, taps); max = max(max, taps).
  - bubbles += bubble, saturating at 255.
  - count += 1.
- Gaps in sample_valid_i are allowed and simply stall the run.
- sample_valid_i outside ACCUM is ignored.
- On the edge accepting sample number 2^LOG2_N:
  - State goes to DONE and the done flag is set.
  - done_o is high for exactly the next cycle.
  - Results are stable from that cycle onward.
- start_i while in ACCUM aborts the run and restarts it with the same clearing as above. No done_o is produced.
- start_i and sample_valid_i in the same cycle: start wins and the sample is dropped.
- Widths:
  - sum: LOG2_N+4 bits, max value 8*2^LOG2_N, no overflow.
  - count: LOG2_N+1 bits.
- mean = sum >> (LOG2_N-4), 8-bit Q4.4, maximum 0x80. It is meaningful only when the done flag is set.
- data_o is registered with one-cycle latency from sel_i; it shows live register contents in all states:
  - sel 0: mean.
  - sel 1: {min[3:0], max[3:0]}; min reads 0xF before the first sample.
  - sel 2: bubble count.
  - sel 3: {busy, done flag, 2'b00, count[3:0]}.
- busy_o is high exactly while in ACCUM.
- Reset asserted mid-run returns to the reset state on the next edge. No done_o is produced.

Decomposition:
- Shared package tdc_pkg holds:
  - state enum (IDLE/ACCUM/DONE).
  - readout select constants SEL_MEAN=0, SEL_MINMAX=1, SEL_BUBBLE=2, SEL_STATUS=3.
  - TAP_W=4 and CODE_W=8.
- Sub-module tdc_therm_decode: combinational, sample_i -> taps[3:0], bubble.

Test Plan:
- LOG2_N=4, start, 16 valid samples of 0x0F:
  - done_o pulses once, the cycle after the 16th sample.
  - sel0=0x40, sel1=0x44, sel2=0x00, sel3=0x40 (count wraps to 0 in the low nibble).
- Alternating 0x00/0xFF, 16 samples with random valid gaps: sel0=0x40, sel1=0x08, busy_o high throughout the run.
- 16 samples of 0x05 (bubble, popcount 2): sel0=0x20, sel1=0x22, sel2=0x10.
- Restart and reset:
  - start_i after 7 samples, then 16 samples of 0x01: no done_o at the restart, sel0=0x10.
  - Separately, rst after 7 samples: all readouts return to 0x00, state IDLE.
- Conflicts and ignored input:
  - start_i with sample_valid_i=1 in the same cycle: that sample is not counted (sel3 count=0 the next cycle).
  - sample_valid_i in IDLE/DONE changes nothing.
- LOG2_N=8, 256 samples of 0xAA:
  - sel2 saturates at 0xFF.
  - sel0=0x40.
  - Exactly one done_o pulse.
